// File: rtl/pixel_plot_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_plot_arbiter_pkg                                                     |
// | Screen geometry, pixel word layout and clear-FSM encodings.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pixel_plot_arbiter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int PIX_W    = X_W + Y_W + COL_W;

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pixel_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CLR_WAIT  = 2'd1;
    localparam logic [1:0] ST_CLR_SWEEP = 2'd2;

    function automatic logic on_screen(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        return (px <= X_LAST) && (py <= Y_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_plot_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_plot_arbiter_if                                                      |
// | Two source pixel streams, clear request and the merged vga_adapter side.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pixel_plot_arbiter_if;
    import pixel_plot_arbiter_pkg::*;

    logic [X_W-1:0]   a_x,      b_x;
    logic [Y_W-1:0]   a_y,      b_y;
    logic [COL_W-1:0] a_colour, b_colour;
    logic             a_plot,   b_plot;
    logic             a_ready,  b_ready;
    logic             clear_start;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
    logic             plot;
    logic             busy;
    logic             clear_done;

    modport master (
        output a_x, a_y, a_colour, a_plot, b_x, b_y, b_colour, b_plot, clear_start,
        input  a_ready, b_ready, x, y, colour, plot, busy, clear_done
    );

    modport slave (
        input  a_x, a_y, a_colour, a_plot, b_x, b_y, b_colour, b_plot, clear_start,
        output a_ready, b_ready, x, y, colour, plot, busy, clear_done
    );

endinterface
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_fifo                                                                 |
// | DEPTH-entry FIFO, two writes (port 0 lands first) and one read per cycle.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 18,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr0_en,
    input  wire logic [WIDTH-1:0] i_wr0_data,
    input  wire logic             i_wr1_en,
    input  wire logic [WIDTH-1:0] i_wr1_data,
    input  wire logic             i_rd_en,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic      [CW-1:0]    o_count,
    output logic      [CW-1:0]    o_free
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_wptr1;

    // Port 1 writes into the slot after port 0 only when port 0 also writes.
    assign w_wptr1 = r_wptr + AW'(i_wr0_en);

    always_ff @(posedge clk) begin
        if (i_wr0_en) r_mem[r_wptr]  <= i_wr0_data;
        if (i_wr1_en) r_mem[w_wptr1] <= i_wr1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_wr0_en) + AW'(i_wr1_en);
            r_rptr  <= r_rptr + AW'(i_rd_en);
            r_count <= r_count + CW'(i_wr0_en) + CW'(i_wr1_en) - CW'(i_rd_en);
        end
    end

    assign o_rd_data = r_mem[r_rptr];
    assign o_count   = r_count;
    assign o_free    = CW'(DEPTH) - r_count;

endmodule
`default_nettype wire

// File: rtl/pixel_plot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_plot_arbiter                                                         |
// | Merges two pixel streams into one plot/cycle and owns a full-screen clear. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_plot_arbiter
    import pixel_plot_arbiter_pkg::*;
#(
    parameter int               DEPTH     = 8,
    parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
    input wire logic          clk,
    input wire logic          reset,
    pixel_plot_arbiter_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             w_busy;
    logic             w_accept_en;
    logic             w_sweeping;
    logic             w_sweep_last;

    logic             r_rr_b;
    logic             w_ready;
    logic             w_acc_a, w_acc_b;
    logic             w_keep_a, w_keep_b;
    pixel_t           w_pix_a, w_pix_b;
    logic             w_wr0_en, w_wr1_en;
    pixel_t           w_wr0_data, w_wr1_data;
    logic             w_rd_en;
    logic             w_empty;
    pixel_t           w_head;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_free;

    logic [X_W-1:0]   r_sx;
    logic [Y_W-1:0]   r_sy;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [COL_W-1:0] r_colour;
    logic             r_plot;
    logic             r_clear_done;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // The sweep waits until the last queued pixel has left the output register.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (bus.clear_start)     w_state_next = ST_CLR_WAIT;
            ST_CLR_WAIT:  if (w_empty && !r_plot)  w_state_next = ST_CLR_SWEEP;
            ST_CLR_SWEEP: if (w_sweep_last)        w_state_next = ST_IDLE;
            default:                               w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != ST_IDLE);
        w_accept_en = (r_state == ST_IDLE);
        w_sweeping  = (r_state == ST_CLR_SWEEP);
    end

    assign w_sweep_last = w_sweeping && (r_sx == X_LAST) && (r_sy == Y_LAST);

    assign w_ready  = w_accept_en && (w_free >= CW'(2)) && !reset;
    assign w_acc_a  = bus.a_plot && w_ready;
    assign w_acc_b  = bus.b_plot && w_ready;
    assign w_keep_a = w_acc_a && on_screen(bus.a_x, bus.a_y);
    assign w_keep_b = w_acc_b && on_screen(bus.b_x, bus.b_y);
    assign w_pix_a  = '{x: bus.a_x, y: bus.a_y, colour: bus.a_colour};
    assign w_pix_b  = '{x: bus.b_x, y: bus.b_y, colour: bus.b_colour};

    // rr decides which source takes the first slot when both survive the filter.
    assign w_wr0_en   = w_keep_a || w_keep_b;
    assign w_wr1_en   = w_keep_a && w_keep_b;
    assign w_wr0_data = (w_keep_b && (!w_keep_a || r_rr_b)) ? w_pix_b : w_pix_a;
    assign w_wr1_data = r_rr_b ? w_pix_a : w_pix_b;

    always_ff @(posedge clk) begin
        if (reset)                  r_rr_b <= 1'b0;
        else if (w_acc_a && w_acc_b) r_rr_b <= ~r_rr_b;
    end

    assign w_empty = (w_count == '0);
    assign w_rd_en = !w_empty && !w_sweeping;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_wr0_en   (w_wr0_en),
        .i_wr0_data (w_wr0_data),
        .i_wr1_en   (w_wr1_en),
        .i_wr1_data (w_wr1_data),
        .i_rd_en    (w_rd_en),
        .o_rd_data  (w_head),
        .o_count    (w_count),
        .o_free     (w_free)
    );

    always_ff @(posedge clk) begin
        if (reset || !w_sweeping) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (r_sx == X_LAST) begin
            r_sx <= '0;
            r_sy <= r_sy + 1'b1;
        end else begin
            r_sx <= r_sx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
            r_plot       <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= w_sweep_last;
            if (w_sweeping) begin
                r_x      <= r_sx;
                r_y      <= r_sy;
                r_colour <= BG_COLOUR;
                r_plot   <= 1'b1;
            end else if (w_rd_en) begin
                r_x      <= w_head.x;
                r_y      <= w_head.y;
                r_colour <= w_head.colour;
                r_plot   <= 1'b1;
            end else begin
                r_plot   <= 1'b0;
            end
        end
    end

    assign bus.a_ready    = w_ready;
    assign bus.b_ready    = w_ready;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.colour     = r_colour;
    assign bus.plot       = r_plot;
    assign bus.busy       = w_busy;
    assign bus.clear_done = r_clear_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_plot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_plot_arbiter                                                      |
// | Scoreboard bench: expected plot stream queued from stimulus, popped on plot.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pixel_plot_arbiter;

    localparam int       DEPTH = 8;
    localparam int       W     = 160;
    localparam int       H     = 120;
    localparam bit [2:0] BG    = 3'b000;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       bg;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pixel_plot_arbiter_if u_if();

    pixel_plot_arbiter #(.DEPTH(DEPTH), .BG_COLOUR(BG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_acc = 0;
    int   n_seen = 0;
    int   bg_seen = 0;
    bit   m_busy = 1'b0;
    bit   m_rr = 1'b0;
    bit   prev_rst = 1'b1;
    bit   sat_chk = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    function automatic bit vis(input int px, input int py);
        return (px < W) && (py < H);
    endfunction

    function automatic exp_t mk(input int px, input int py, input int pc);
        exp_t e;
        e.x = 8'(px); e.y = 7'(py); e.c = 3'(pc); e.bg = 1'b0; e.last = 1'b0;
        return e;
    endfunction

    // Monitor + reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   done_exp;
        bit   er;
        bit   ha, hb, ka, kb;
        done_exp = 1'b0;
        if (prev_rst) begin
            check("rst_plot", u_if.plot, 0);
            check("rst_xyc", {u_if.x, u_if.y, u_if.colour}, 0);
            check("rst_busy", u_if.busy, 0);
            check("rst_done", u_if.clear_done, 0);
        end else if (u_if.plot) begin
            if (exp_q.size() == 0) begin
                check("unexpected_plot", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pixel", {u_if.x, u_if.y, u_if.colour}, {e.x, e.y, e.c});
                if (e.bg) begin
                    bg_seen++;
                    if (e.last) begin
                        done_exp = 1'b1;
                        m_busy = 1'b0;
                    end
                end else begin
                    n_seen++;
                end
            end
        end else if (sat_chk) begin
            check("sat_plot", u_if.plot, 1);
        end
        if (!prev_rst) begin
            check("clear_done", u_if.clear_done, int'(done_exp));
            check("busy", u_if.busy, int'(m_busy));
        end
        er = !reset && !m_busy && ((DEPTH - (n_acc - n_seen)) >= 2);
        check("a_ready", u_if.a_ready, int'(er));
        check("b_ready", u_if.b_ready, int'(er));

        if (reset) begin
            exp_q.delete();
            n_acc = 0; n_seen = 0; m_busy = 1'b0; m_rr = 1'b0;
        end else begin
            ha = u_if.a_plot && er;
            hb = u_if.b_plot && er;
            ka = ha && vis(u_if.a_x, u_if.a_y);
            kb = hb && vis(u_if.b_x, u_if.b_y);
            if (ha && hb && m_rr) begin
                if (kb) exp_q.push_back(mk(u_if.b_x, u_if.b_y, u_if.b_colour));
                if (ka) exp_q.push_back(mk(u_if.a_x, u_if.a_y, u_if.a_colour));
            end else begin
                if (ka) exp_q.push_back(mk(u_if.a_x, u_if.a_y, u_if.a_colour));
                if (kb) exp_q.push_back(mk(u_if.b_x, u_if.b_y, u_if.b_colour));
            end
            if (ha && hb) m_rr = !m_rr;
            n_acc += int'(ka) + int'(kb);
            if (u_if.clear_start && !m_busy) begin
                for (int yy = 0; yy < H; yy++) begin
                    for (int xx = 0; xx < W; xx++) begin
                        e = mk(xx, yy, BG);
                        e.bg = 1'b1;
                        e.last = (xx == W - 1) && (yy == H - 1);
                        exp_q.push_back(e);
                    end
                end
                m_busy = 1'b1;
            end
        end
        prev_rst = reset;
    end

    task automatic set_in(input bit ap, input int ax, input int ay, input int ac,
                          input bit bp, input int bx, input int by, input int bc, input bit cs);
        u_if.a_plot = ap; u_if.a_x = 8'(ax); u_if.a_y = 7'(ay); u_if.a_colour = 3'(ac);
        u_if.b_plot = bp; u_if.b_x = 8'(bx); u_if.b_y = 7'(by); u_if.b_colour = 3'(bc);
        u_if.clear_start = cs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ap, input int ax, input int ay, input int ac,
                         input bit bp, input int bx, input int by, input int bc, input bit cs);
        set_in(ap, ax, ay, ac, bp, bx, by, bc, cs);
        tick();
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        while ((exp_q.size() != 0 || m_busy) && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(exp_q.size() == 0 && !m_busy), 1);
        idle(2);
    endtask

    // Single A pixel into an empty FIFO: plot one cycle after the accept edge.
    task automatic latency_probe(input string name, input int px, input int py, input int pc);
        drive(1, px, py, pc, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check({name, "_gap"}, u_if.plot, 0);
        @(negedge clk);
        check({name, "_plot"}, u_if.plot, 1);
        check({name, "_xyc"}, {u_if.x, u_if.y, u_if.colour}, {8'(px), 7'(py), 3'(pc)});
        @(negedge clk);
        check({name, "_after"}, u_if.plot, 0);
        tick();
    endtask

    initial begin
        int base;
        int n;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        idle(2);

        latency_probe("t1", 10, 20, 3'b010);

        drive(1, 1, 1, 1, 1, 2, 2, 2, 0);
        drive(1, 3, 3, 3, 1, 4, 4, 4, 0);
        wait_drain("t2_drain", 50);

        drive(1, 160, 5, 1, 0, 0, 0, 0, 0);
        drive(1, 5, 120, 2, 1, 200, 0, 3, 0);
        drive(1, 159, 119, 7, 1, 0, 0, 5, 0);
        wait_drain("t4_drain", 50);

        for (int i = 0; i < 40; i++) begin
            if (i == 3) sat_chk = 1'b1;
            drive(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7),
                  1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), 0);
        end
        sat_chk = 1'b0;
        wait_drain("t3_drain", 100);

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7), 0);
        end
        wait_drain("rand_drain", 100);

        drive(1, 11, 12, 1, 1, 13, 14, 2, 0);
        drive(1, 15, 16, 3, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            drive(1, i, i, 4, 1, i + 1, i, 5, 0);
        end
        wait_drain("t5_sweep", 25000);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        base = bg_seen;
        n = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (bg_seen < base + 5000 && n < 10000) begin
            tick();
            n++;
        end
        check("t6_reach5000", int'(bg_seen >= base + 5000), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        latency_probe("t6", 42, 17, 3'b101);
        drive(1, 30, 31, 6, 1, 32, 33, 1, 0);
        wait_drain("t6_drain", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
